// File: rtl/audio_pkg.sv
// Shared types and constants for the beamformed-audio UART path.
package audio_pkg;

  localparam int         AUDIO_WIDTH       = 24;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT
  } framer_state_t;

endpackage

// File: rtl/audio_uart_framer_if.sv
// Sample-in / byte-out bundle between the DSS stage, the framer and the UART.
interface audio_uart_framer_if #(
  parameter int FIFO_DEPTH = 16
);
  import audio_pkg::*;

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic signed [AUDIO_WIDTH-1:0] sample_in;
  logic                          valid_in;
  logic                          enable_in;
  logic                          busy_in;
  logic        [7:0]             byte_out;
  logic                          trigger_out;
  logic        [LEVEL_W-1:0]     fifo_level_out;
  logic        [15:0]            overflow_count_out;

  // Framer side.
  modport slave (
    input  sample_in, valid_in, enable_in, busy_in,
    output byte_out, trigger_out, fifo_level_out, overflow_count_out
  );

  // Producer / transmitter side.
  modport master (
    output sample_in, valid_in, enable_in, busy_in,
    input  byte_out, trigger_out, fifo_level_out, overflow_count_out
  );

endinterface

// File: rtl/audio_uart_framer_fifo.sv
// Synchronous sample FIFO with explicit level tracking and registered read data.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level_q;
  logic               do_push;
  logic               do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a write when a slot frees up in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign level   = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage and read port; read data is valid the cycle after pop.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= wr_data;
    if (do_pop)  rd_data     <= mem[rd_ptr];
  end

endmodule

// File: rtl/audio_uart_framer.sv
// Buffers DSS samples and sends each as SYNC_BYTE followed by MSB-first data bytes.
module audio_uart_framer
  import audio_pkg::*;
#(
  parameter int         SAMPLE_BYTES = 2,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         HOLD_CYCLES  = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  audio_uart_framer_if.slave  bus
);

  localparam int DATA_W  = 8 * SAMPLE_BYTES;
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  framer_state_t      state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [7:0]         byte_q, byte_d;
  logic               trig_q, trig_d;
  logic [DATA_W-1:0]  shift_q;
  logic               shift_adv;
  logic               pop;
  logic               pop_p1;
  logic               push;
  logic               drop_full;
  logic [15:0]        overflow_q;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Keep only the top SAMPLE_BYTES bytes of the sample.
  assign wr_data   = bus.sample_in[AUDIO_WIDTH-1 -: DATA_W];
  assign push      = bus.valid_in && bus.enable_in && (!fifo_full || pop);
  assign drop_full = bus.valid_in && bus.enable_in && fifo_full && !pop;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Frame sequencing: next state, byte selection and trigger decision.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    byte_d    = byte_q;
    trig_d    = 1'b0;
    pop       = 1'b0;
    shift_adv = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.busy_in) begin
          pop     = 1'b1;
          byte_d  = SYNC_BYTE;
          trig_d  = 1'b1;
          idx_d   = '0;
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES)) state_d = WAIT;
        else                                hold_d  = hold_q + 1'b1;
      end
      WAIT: begin
        if (!bus.busy_in) begin
          if (idx_q == 2'(SAMPLE_BYTES)) begin
            state_d = IDLE;
          end else begin
            byte_d    = shift_q[DATA_W-1 -: 8];
            shift_adv = 1'b1;
            trig_d    = 1'b1;
            idx_d     = idx_q + 1'b1;
            hold_d    = '0;
            state_d   = HOLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, registered outputs and the saturating overflow counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      byte_q     <= '0;
      trig_q     <= 1'b0;
      pop_p1     <= 1'b0;
      overflow_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
      trig_q  <= trig_d;
      pop_p1  <= pop;
      if (drop_full) overflow_q <= sat_inc16(overflow_q);
    end
  end

  // Shift register loads the popped sample once FIFO read data lands.
  always_ff @(posedge clk_in) begin
    if (pop_p1)         shift_q <= rd_data;
    else if (shift_adv) shift_q <= shift_q << 8;
  end

  assign bus.byte_out           = byte_q;
  assign bus.trigger_out        = trig_q;
  assign bus.fifo_level_out     = fifo_level;
  assign bus.overflow_count_out = overflow_q;

endmodule

// File: tb/tb_audio_uart_framer.sv
// Directed bench for audio_uart_framer with a busy-after-trigger UART model.
module tb_audio_uart_framer;
  import audio_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  audio_uart_framer_if #(.FIFO_DEPTH(16)) bus ();

  audio_uart_framer #(
    .SAMPLE_BYTES (2),
    .FIFO_DEPTH   (16),
    .SYNC_BYTE    (8'hA5),
    .HOLD_CYCLES  (2)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // busy_mode: 0 = idle transmitter, 1 = busy for busy_len cycles after each trigger, 2 = stuck busy
  int busy_mode = 0;
  int busy_len  = 100;
  int busy_cnt  = 0;
  assign bus.busy_in = (busy_mode == 2) || (busy_mode == 1 && busy_cnt != 0);

  always @(posedge clk_in) begin
    if (rst_in)               busy_cnt <= 0;
    else if (bus.trigger_out) busy_cnt <= busy_len;
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end

  logic [7:0] byte_q[$];
  int   trig_count  = 0;
  int   busy_viol   = 0;
  int   consec_viol = 0;
  int   max_level   = 0;
  logic prev_busy   = 1'b0;
  logic prev_trig   = 1'b0;

  always begin
    @(negedge clk_in);
    #1;
    if (rst_in) begin
      prev_trig = 1'b0;
    end else begin
      if (bus.trigger_out) begin
        byte_q.push_back(bus.byte_out);
        trig_count++;
        if (prev_busy) busy_viol++;
        if (prev_trig) consec_viol++;
      end
      prev_trig = bus.trigger_out;
      if (int'(bus.fifo_level_out) > max_level) max_level = int'(bus.fifo_level_out);
    end
    prev_busy = bus.busy_in;
  end

  task automatic send_sample(input logic [23:0] v);
    bus.sample_in = v;
    bus.valid_in  = 1'b1;
    @(negedge clk_in);
    bus.valid_in  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in       = 1'b1;
    bus.valid_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    byte_q.delete();
    trig_count  = 0;
    busy_viol   = 0;
    consec_viol = 0;
    max_level   = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    checks++; if (bus.byte_out !== 8'h00) begin errors++; $display("FAIL rst_byte: got %0h expected 0", bus.byte_out); end
    checks++; if (bus.trigger_out !== 1'b0) begin errors++; $display("FAIL rst_trigger: got %0b expected 0", bus.trigger_out); end
    checks++; if (bus.fifo_level_out !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", bus.fifo_level_out); end
    checks++; if (bus.overflow_count_out !== 16'd0) begin errors++; $display("FAIL rst_overflow: got %0d expected 0", bus.overflow_count_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [7:0] exp[$];
    logic [8:0] got;
    busy_mode = 0;
    byte_q.delete();
    trig_count = 0;
    send_sample(24'h123456);
    checks++; if (bus.fifo_level_out !== 5'd1) begin errors++; $display("FAIL single_level_t1: got %0d expected 1", bus.fifo_level_out); end
    checks++; if (bus.trigger_out !== 1'b0) begin errors++; $display("FAIL single_trig_t1: got %0b expected 0", bus.trigger_out); end
    @(negedge clk_in);
    checks++; if (bus.trigger_out !== 1'b1) begin errors++; $display("FAIL single_trig_t2: got %0b expected 1", bus.trigger_out); end
    checks++; if (bus.byte_out !== 8'hA5) begin errors++; $display("FAIL single_sync_t2: got %0h expected a5", bus.byte_out); end
    repeat (20) @(negedge clk_in);
    exp = '{8'hA5, 8'h12, 8'h34};
    checks++; if (byte_q.size() !== 3) begin errors++; $display("FAIL single_count: got %0d expected 3", byte_q.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < byte_q.size()) ? {1'b0, byte_q[i]} : 9'h1FF;
      checks++; if (got !== {1'b0, exp[i]}) begin errors++; $display("FAIL single_byte%0d: got %0h expected %0h", i, got, exp[i]); end
    end
    checks++; if (consec_viol !== 0) begin errors++; $display("FAIL single_consec: got %0d expected 0", consec_viol); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] exp[$];
    logic [8:0] got;
    int waited;
    do_reset();
    busy_mode = 1;
    busy_len  = 100;
    bus.sample_in = 24'h102030; bus.valid_in = 1'b1; @(negedge clk_in);
    bus.sample_in = 24'h405060; @(negedge clk_in);
    bus.sample_in = 24'h708090; @(negedge clk_in);
    bus.valid_in = 1'b0;
    waited = 0;
    while (byte_q.size() < 9 && waited < 2000) begin @(negedge clk_in); waited++; end
    checks++; if (byte_q.size() < 9) begin errors++; $display("FAIL bp_timeout: got %0d bytes expected 9", byte_q.size()); end
    repeat (150) @(negedge clk_in);
    exp = '{8'hA5, 8'h10, 8'h20, 8'hA5, 8'h40, 8'h50, 8'hA5, 8'h70, 8'h80};
    checks++; if (byte_q.size() !== 9) begin errors++; $display("FAIL bp_count: got %0d expected 9", byte_q.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < byte_q.size()) ? {1'b0, byte_q[i]} : 9'h1FF;
      checks++; if (got !== {1'b0, exp[i]}) begin errors++; $display("FAIL bp_byte%0d: got %0h expected %0h", i, got, exp[i]); end
    end
    checks++; if (busy_viol !== 0) begin errors++; $display("FAIL bp_trig_while_busy: got %0d expected 0", busy_viol); end
    checks++; if (consec_viol !== 0) begin errors++; $display("FAIL bp_consec: got %0d expected 0", consec_viol); end
    checks++; if (max_level !== 2) begin errors++; $display("FAIL bp_peak_level: got %0d expected 2", max_level); end
  endtask

  task automatic test_overflow();
    do_reset();
    busy_mode = 1;
    busy_len  = 1000000;
    for (int k = 1; k <= 20; k++) begin
      bus.sample_in = {8'(k), 8'(8'h80 + k), 8'h5A};
      bus.valid_in  = 1'b1;
      @(negedge clk_in);
    end
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (bus.fifo_level_out !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", bus.fifo_level_out); end
    checks++; if (bus.overflow_count_out !== 16'd3) begin errors++; $display("FAIL ovf_count: got %0d expected 3", bus.overflow_count_out); end
    checks++; if (trig_count !== 1) begin errors++; $display("FAIL ovf_triggers: got %0d expected 1", trig_count); end
    checks++; if (bus.byte_out !== 8'hA5) begin errors++; $display("FAIL ovf_byte: got %0h expected a5", bus.byte_out); end
  endtask

  // Runs straight after test_overflow: FIFO full, framer stalled after the sync byte.
  task automatic test_full_pop();
    logic [7:0] exp[$];
    logic [8:0] got;
    int waited;
    busy_mode = 0;
    // Remaining two data bytes plus the return to IDLE put the next pop 9 edges out.
    repeat (9) @(negedge clk_in);
    bus.sample_in = 24'hC3D4E5;
    bus.valid_in  = 1'b1;
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    checks++; if (bus.fifo_level_out !== 5'd16) begin errors++; $display("FAIL fullpop_level: got %0d expected 16", bus.fifo_level_out); end
    checks++; if (bus.overflow_count_out !== 16'd3) begin errors++; $display("FAIL fullpop_overflow: got %0d expected 3", bus.overflow_count_out); end
    checks++; if (bus.trigger_out !== 1'b1) begin errors++; $display("FAIL fullpop_trigger: got %0b expected 1", bus.trigger_out); end
    waited = 0;
    while (byte_q.size() < 54 && waited < 3000) begin @(negedge clk_in); waited++; end
    repeat (20) @(negedge clk_in);
    exp.push_back(8'hA5); exp.push_back(8'h01); exp.push_back(8'h81);
    for (int k = 2; k <= 17; k++) begin
      exp.push_back(8'hA5); exp.push_back(8'(k)); exp.push_back(8'(8'h80 + k));
    end
    exp.push_back(8'hA5); exp.push_back(8'hC3); exp.push_back(8'hD4);
    checks++; if (byte_q.size() !== 54) begin errors++; $display("FAIL drain_count: got %0d expected 54", byte_q.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < byte_q.size()) ? {1'b0, byte_q[i]} : 9'h1FF;
      checks++; if (got !== {1'b0, exp[i]}) begin errors++; $display("FAIL drain_byte%0d: got %0h expected %0h", i, got, exp[i]); end
    end
    checks++; if (bus.fifo_level_out !== 5'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", bus.fifo_level_out); end
  endtask

  task automatic test_enable();
    do_reset();
    busy_mode     = 0;
    bus.enable_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_sample(24'h777777);
      @(negedge clk_in);
    end
    repeat (10) @(negedge clk_in);
    checks++; if (bus.fifo_level_out !== 5'd0) begin errors++; $display("FAIL en_level: got %0d expected 0", bus.fifo_level_out); end
    checks++; if (bus.overflow_count_out !== 16'd0) begin errors++; $display("FAIL en_overflow: got %0d expected 0", bus.overflow_count_out); end
    checks++; if (trig_count !== 0) begin errors++; $display("FAIL en_triggers: got %0d expected 0", trig_count); end
    bus.enable_in = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    busy_mode     = 2;
    bus.sample_in = 24'h5A5A5A;
    bus.valid_in  = 1'b1;
    repeat (1016) @(negedge clk_in);
    checks++; if (bus.overflow_count_out !== 16'd1000) begin errors++; $display("FAIL sat_mid: got %0d expected 1000", bus.overflow_count_out); end
    checks++; if (bus.fifo_level_out !== 5'd16) begin errors++; $display("FAIL sat_level: got %0d expected 16", bus.fifo_level_out); end
    repeat (69000) @(negedge clk_in);
    bus.valid_in = 1'b0;
    @(negedge clk_in);
    checks++; if (bus.overflow_count_out !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %0h expected ffff", bus.overflow_count_out); end
    checks++; if (trig_count !== 0) begin errors++; $display("FAIL sat_triggers: got %0d expected 0", trig_count); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp[$];
    logic [8:0] got;
    do_reset();
    busy_mode = 0;
    bus.sample_in = 24'h111111; bus.valid_in = 1'b1; @(negedge clk_in);
    bus.sample_in = 24'h222222; @(negedge clk_in);
    bus.valid_in = 1'b0;
    checks++; if (bus.trigger_out !== 1'b1) begin errors++; $display("FAIL mid_sync_trig: got %0b expected 1", bus.trigger_out); end
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++; if (bus.trigger_out !== 1'b0) begin errors++; $display("FAIL mid_trig: got %0b expected 0", bus.trigger_out); end
    checks++; if (bus.fifo_level_out !== 5'd0) begin errors++; $display("FAIL mid_level: got %0d expected 0", bus.fifo_level_out); end
    checks++; if (bus.byte_out !== 8'h00) begin errors++; $display("FAIL mid_byte: got %0h expected 0", bus.byte_out); end
    rst_in = 1'b0;
    byte_q.delete();
    send_sample(24'hABCDEF);
    repeat (20) @(negedge clk_in);
    exp = '{8'hA5, 8'hAB, 8'hCD};
    checks++; if (byte_q.size() !== 3) begin errors++; $display("FAIL mid_count: got %0d expected 3", byte_q.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < byte_q.size()) ? {1'b0, byte_q[i]} : 9'h1FF;
      checks++; if (got !== {1'b0, exp[i]}) begin errors++; $display("FAIL mid_byte%0d: got %0h expected %0h", i, got, exp[i]); end
    end
  endtask

  initial begin
    bus.sample_in = '0;
    bus.valid_in  = 1'b0;
    bus.enable_in = 1'b1;
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_overflow();
    test_full_pop();
    test_enable();
    test_saturation();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
